// File: rtl/key_conditioner.sv
// Four-line key synchroniser and debouncer feeding the priority encoder input.
// Optional sticky/acknowledge output register is enabled with `define KEY_LATCH_EN.
module key_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] key_out,
    output logic             key_valid,
    output logic             key_changed
);

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] key_out_q, key_out_d;
    logic             key_changed_q, key_changed_d;

    always_comb begin
        stable_d = stable_q;
        state_d  = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == stable_q[i]) begin
                // Equal level in either state: idle, or a glitch that restarts the count.
                state_d[i] = ST_STABLE;
            end else if (state_q[i] == ST_STABLE) begin
                state_d[i] = ST_PENDING;
                cnt_d[i]   = CNT_W'(1);
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i]  = ST_STABLE;
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef KEY_LATCH_EN
    logic [WIDTH-1:0] rise;

    always_comb begin
        rise = stable_d & ~stable_q;
        // A press landing in the ack cycle survives the clear.
        if (ack) begin
            key_out_d = rise;
        end else begin
            key_out_d = key_out_q | rise;
        end
    end
`else
    logic unused_ack;

    assign unused_ack = ack;

    always_comb begin
        key_out_d = stable_d;
    end
`endif

    always_comb begin
        key_changed_d = (key_out_d != key_out_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            state_q       <= '0;
            key_out_q     <= '0;
            key_changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= key_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            state_q       <= state_d;
            key_out_q     <= key_out_d;
            key_changed_q <= key_changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_out     = key_out_q;
    assign key_valid   = |key_out_q;
    assign key_changed = key_changed_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed, table-driven bench for key_conditioner with DEBOUNCE_CYCLES=4.
// Define KEY_LATCH_EN for both files to exercise the sticky/acknowledge build.
module tb_key_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_raw;
    logic       ack;
    logic [3:0] key_out;
    logic       key_valid;
    logic       key_changed;

    int tests;
    int failed;

    typedef struct {
        string      name;
        logic [3:0] raw;
        logic       ack;
        int         steps;
        logic [3:0] out;
        logic       valid;
        int         pulses;
    } vec_t;

    vec_t tbl[$];

    key_conditioner #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_raw(key_raw),
        .ack(ack),
        .key_out(key_out),
        .key_valid(key_valid),
        .key_changed(key_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] raw, input logic a, input int steps,
                       input logic [3:0] out, input logic valid, input int pulses);
        vec_t v;
        v.name   = name;
        v.raw    = raw;
        v.ack    = a;
        v.steps  = steps;
        v.out    = out;
        v.valid  = valid;
        v.pulses = pulses;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        tests   = 0;
        failed  = 0;
        key_raw = 4'b0000;
        ack     = 1'b0;
        reset_n = 1'b0;

`ifdef KEY_LATCH_EN
        add("latch_press_wait",   4'b0100, 1'b0, 5, 4'b0000, 1'b0, 0);
        add("latch_press_land",   4'b0100, 1'b0, 1, 4'b0100, 1'b1, 1);
        add("latch_release_hold", 4'b0000, 1'b0, 6, 4'b0100, 1'b1, 0);
        add("latch_ack_clear",    4'b0000, 1'b1, 1, 4'b0000, 1'b0, 1);
        add("latch_idle",         4'b0000, 1'b0, 2, 4'b0000, 1'b0, 0);
        add("latch_press2",       4'b0100, 1'b0, 6, 4'b0100, 1'b1, 1);
        add("latch_b0_pending",   4'b0101, 1'b0, 5, 4'b0100, 1'b1, 0);
        add("latch_ack_coincide", 4'b0101, 1'b1, 1, 4'b0001, 1'b1, 1);
        add("latch_after_ack",    4'b0101, 1'b0, 2, 4'b0001, 1'b1, 0);
        add("latch_glitch_b3",    4'b1101, 1'b0, 3, 4'b0001, 1'b1, 0);
        add("latch_glitch_done",  4'b0101, 1'b0, 6, 4'b0001, 1'b1, 0);
`else
        add("press0_wait",     4'b0001, 1'b0, 5, 4'b0000, 1'b0, 0);
        add("press0_land",     4'b0001, 1'b0, 1, 4'b0001, 1'b1, 1);
        add("press0_hold",     4'b0001, 1'b0, 2, 4'b0001, 1'b1, 0);
        add("glitch2_pulse",   4'b0101, 1'b0, 3, 4'b0001, 1'b1, 0);
        add("glitch2_settle",  4'b0001, 1'b0, 8, 4'b0001, 1'b1, 0);
        add("release0_wait",   4'b0000, 1'b0, 5, 4'b0001, 1'b1, 0);
        add("release0_land",   4'b0000, 1'b0, 1, 4'b0000, 1'b0, 1);
        add("press01_wait",    4'b0011, 1'b0, 5, 4'b0000, 1'b0, 0);
        add("press01_land",    4'b0011, 1'b0, 1, 4'b0011, 1'b1, 1);
        add("press01_ack_ign", 4'b0011, 1'b1, 3, 4'b0011, 1'b1, 0);
        add("release01_wait",  4'b0000, 1'b0, 5, 4'b0011, 1'b1, 0);
        add("release01_land",  4'b0000, 1'b0, 1, 4'b0000, 1'b0, 1);
        add("multihot",        4'b1111, 1'b0, 6, 4'b1111, 1'b1, 1);
        add("multihot_rel",    4'b0000, 1'b0, 6, 4'b0000, 1'b0, 1);
`endif

        #12;
        chk("rst_key_out",     32'(key_out), 32'h0);
        chk("rst_key_valid",   32'(key_valid), 32'h0);
        chk("rst_key_changed", 32'(key_changed), 32'h0);
        step();
        reset_n = 1'b1;

        for (int v = 0; v < tbl.size(); v++) begin
            key_raw = tbl[v].raw;
            ack     = tbl[v].ack;
            pulses  = 0;
            for (int s = 0; s < tbl[v].steps; s++) begin
                step();
                if (key_changed) pulses++;
            end
            chk({tbl[v].name, "_out"},    32'(key_out), 32'(tbl[v].out));
            chk({tbl[v].name, "_valid"},  32'(key_valid), 32'(tbl[v].valid));
            chk({tbl[v].name, "_pulses"}, 32'(pulses), 32'(tbl[v].pulses));
        end
        ack = 1'b0;

        // Reset mid-debounce discards the partial count.
        key_raw = 4'b1000;
        for (int s = 0; s < 4; s++) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_key_out",     32'(key_out), 32'h0);
        chk("midrst_key_valid",   32'(key_valid), 32'h0);
        chk("midrst_key_changed", 32'(key_changed), 32'h0);
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (key_changed) pulses++;
        end
        chk("postrst_wait_out",    32'(key_out), 32'h0);
        chk("postrst_wait_pulses", 32'(pulses), 32'h0);
        step();
        chk("postrst_land_out",     32'(key_out), 32'h8);
        chk("postrst_land_valid",   32'(key_valid), 32'h1);
        chk("postrst_land_changed", 32'(key_changed), 32'h1);
        step();
        chk("postrst_changed_drop", 32'(key_changed), 32'h0);

        // Asynchronous reset clears a non-zero output without waiting for an edge.
        #3;
        reset_n = 1'b0;
        #1;
        chk("asyncrst_key_out",   32'(key_out), 32'h0);
        chk("asyncrst_key_valid", 32'(key_valid), 32'h0);
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
